// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execute stage.
// Opcode encodings 8-15 are left unassigned and treated as illegal by the execute unit.
package instr_register_pkg;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] operand_r;
    typedef logic [4:0]         address_t;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        DIV_RUN,
        DONE
    } exec_state_t;

    localparam int unsigned DIV_WIDTH = 32;

    function automatic logic is_div_op(opcode_t opc);
        return (opc == DIV) || (opc == MOD);
    endfunction

endpackage

// File: rtl/instr_divider.sv
// Iterative unsigned restoring divider resolving STEPS quotient bits per cycle.
// done_o flags the final cycle; quotient_o/remainder_o carry that cycle's finished result.
module instr_divider #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEPS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int unsigned CYCLES = WIDTH / STEPS;
    localparam int unsigned CW     = $clog2(CYCLES + 1);

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] trial;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        shifted = '0;
        trial   = '0;
        if (start_i) begin
            quo_d = dividend_i;
            rem_d = '0;
            dvs_d = divisor_i;
            cnt_d = CW'(CYCLES);
        end else if (cnt_q != '0) begin
            for (int unsigned i = 0; i < STEPS; i++) begin
                // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value
                shifted = {rem_d, quo_d[WIDTH-1]};
                trial   = shifted - {1'b0, dvs_q};
                quo_d   = {quo_d[WIDTH-2:0], ~trial[WIDTH]};
                rem_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            end
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign done_o      = (cnt_q == CW'(1));
    assign quotient_o  = quo_d;
    assign remainder_o = rem_d;

endmodule

// File: rtl/instr_exec_unit.sv
// Execute stage: single-cycle ALU ops plus an iterative signed DIV/MOD, one instruction in flight,
// result held in an output register until the consumer takes it.
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int unsigned DIV_STEPS_PER_CYCLE = 1
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     in_valid,
    output logic     in_ready,
    input  opcode_t  in_opc,
    input  operand_t in_op_a,
    input  operand_t in_op_b,
    input  address_t in_addr,
    output logic     out_valid,
    input  logic     out_ready,
    output opcode_t  out_opc,
    output address_t out_addr,
    output operand_r out_op_r,
    output logic     out_err,
    output logic     busy
);

    exec_state_t state_q, state_d;
    opcode_t     opc_q, opc_d;
    address_t    addr_q, addr_d;
    operand_r    res_q, res_d;
    logic        err_q, err_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;

    logic                 accept;
    logic                 div_nz;
    logic                 div_start;
    logic                 div_done;
    logic [DIV_WIDTH-1:0] mag_a, mag_b;
    logic [DIV_WIDTH-1:0] div_quo, div_rem;
    logic [63:0]          quo_ext, rem_ext;
    operand_r             quo_fix, rem_fix;
    operand_r             sc_res;
    logic                 sc_err;

    assign in_ready  = reset_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign div_nz    = is_div_op(in_opc) && (in_op_b != '0);
    assign div_start = accept && div_nz;

    // Two's-complement negation of -2^31 yields 0x80000000, the correct unsigned magnitude
    assign mag_a = in_op_a[31] ? (~in_op_a + 32'd1) : in_op_a;
    assign mag_b = in_op_b[31] ? (~in_op_b + 32'd1) : in_op_b;

    instr_divider #(
        .WIDTH (DIV_WIDTH),
        .STEPS (DIV_STEPS_PER_CYCLE)
    ) u_divider (
        .clk         (clk),
        .rst_n       (reset_n),
        .start_i     (div_start),
        .dividend_i  (mag_a),
        .divisor_i   (mag_b),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    assign quo_ext = {32'b0, div_quo};
    assign rem_ext = {32'b0, div_rem};
    assign quo_fix = neg_quo_q ? operand_r'(~quo_ext + 64'd1) : operand_r'(quo_ext);
    assign rem_fix = neg_rem_q ? operand_r'(~rem_ext + 64'd1) : operand_r'(rem_ext);

    always_comb begin
        sc_res = '0;
        sc_err = 1'b0;
        case (in_opc)
            ZERO:    sc_res = '0;
            PASSA:   sc_res = operand_r'(in_op_a);
            PASSB:   sc_res = operand_r'(in_op_b);
            ADD:     sc_res = operand_r'(in_op_a) + operand_r'(in_op_b);
            SUB:     sc_res = operand_r'(in_op_a) - operand_r'(in_op_b);
            MULT:    sc_res = operand_r'(in_op_a) * operand_r'(in_op_b);
            // DIV/MOD only take this path with a zero divisor
            DIV,
            MOD:     sc_err = 1'b1;
            default: sc_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        addr_d    = addr_q;
        res_d     = res_q;
        err_d     = err_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (accept) begin
            opc_d     = in_opc;
            addr_d    = in_addr;
            neg_quo_d = in_op_a[31] ^ in_op_b[31];
            neg_rem_d = in_op_a[31];
            if (div_nz) begin
                state_d = DIV_RUN;
                res_d   = '0;
                err_d   = 1'b0;
            end else begin
                state_d = DONE;
                res_d   = sc_res;
                err_d   = sc_err;
            end
        end else begin
            case (state_q)
                DIV_RUN: begin
                    if (div_done) begin
                        state_d = DONE;
                        res_d   = (opc_q == MOD) ? rem_fix : quo_fix;
                    end
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            opc_q     <= ZERO;
            addr_q    <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            addr_q    <= addr_d;
            res_q     <= res_d;
            err_q     <= err_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_opc   = opc_q;
    assign out_addr  = addr_q;
    assign out_op_r  = res_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Randomized self-checking bench for instr_exec_unit against an integer-arithmetic reference model.
module tb_instr_exec_unit;
    import instr_register_pkg::*;

    localparam int S = 1;

    logic     clk = 1'b0;
    logic     reset_n = 1'b0;
    logic     in_valid = 1'b0;
    logic     in_ready;
    opcode_t  in_opc = ZERO;
    operand_t in_op_a = '0;
    operand_t in_op_b = '0;
    address_t in_addr = '0;
    logic     out_valid;
    logic     out_ready = 1'b0;
    opcode_t  out_opc;
    address_t out_addr;
    operand_r out_op_r;
    logic     out_err;
    logic     busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_exec_unit #(.DIV_STEPS_PER_CYCLE(S)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opc    (in_opc),
        .in_op_a   (in_op_a),
        .in_op_b   (in_op_b),
        .in_addr   (in_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_opc   (out_opc),
        .out_addr  (out_addr),
        .out_op_r  (out_op_r),
        .out_err   (out_err),
        .busy      (busy)
    );

    // Reference: plain 64-bit integer arithmetic (SV / and % truncate toward zero)
    function automatic void model(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] r, output logic err);
        longint la, lb, lr;
        la = $signed(a);
        lb = $signed(b);
        lr = 0;
        err = 1'b0;
        case (opc)
            4'd0: lr = 0;
            4'd1: lr = la;
            4'd2: lr = lb;
            4'd3: lr = la + lb;
            4'd4: lr = la - lb;
            4'd5: lr = la * lb;
            4'd6: if (lb == 0) err = 1'b1; else lr = la / lb;
            4'd7: if (lb == 0) err = 1'b1; else lr = la % lb;
            default: err = 1'b1;
        endcase
        r = lr;
    endfunction

    function automatic int exp_latency(input logic [3:0] opc, input logic [31:0] b);
        return ((opc == 4'd6 || opc == 4'd7) && b != 0) ? 1 + 32 / S : 1;
    endfunction

    function automatic logic [31:0] rand_divisor();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom_range(1, 20);
            1: v = -$urandom_range(1, 20);
            2: v = $urandom_range(1, 70000);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issues one instruction, waits for its result, captures it, then drains it
    task automatic do_op(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] addr, output logic [63:0] r, output logic err,
                         output logic [3:0] oopc, output logic [4:0] oaddr,
                         output int lat, output int rdy_hi);
        int n;
        @(negedge clk);
        in_opc   = opcode_t'(opc);
        in_op_a  = a;
        in_op_b  = b;
        in_addr  = addr;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!in_ready) begin
            fails++;
            $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        rdy_hi = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) rdy_hi++;
        end while (!out_valid && lat < 100);
        r     = out_op_r;
        err   = out_err;
        oopc  = out_opc;
        oaddr = out_addr;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || out_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags got valid=%b ready=%b busy=%b err=%b required 0000",
                     out_valid, in_ready, busy, out_err);
        end
        tests++;
        if (out_op_r !== 64'd0 || out_addr !== 5'd0 || out_opc !== ZERO) begin
            fails++;
            $display("FAIL reset_data got r=%h addr=%h opc=%0d required 0/0/0", out_op_r, out_addr, out_opc);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle got ready=%b valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        logic [3:0]  to[7] = '{4'd3, 4'd4, 4'd5, 4'd5, 4'd1, 4'd2, 4'd0};
        logic [31:0] ta[7] = '{32'h7FFFFFFF, 32'h0, 32'hFFFFFFFD, 32'h80000000, 32'h12345678, 32'h1, 32'hDEADBEEF};
        logic [31:0] tb[7] = '{32'h1, 32'h1, 32'h7, 32'h80000000, 32'h9, 32'h87654321, 32'h5};
        logic [3:0] opc, oopc;
        logic [31:0] a, b;
        logic [4:0] addr, oaddr;
        logic [63:0] r, er;
        logic err, ee;
        int lat, rdy;
        for (int i = 0; i < 37; i++) begin
            if (i < 7) begin
                opc = to[i]; a = ta[i]; b = tb[i];
            end else begin
                opc = 4'($urandom_range(0, 5)); a = $urandom; b = $urandom;
            end
            addr = 5'($urandom);
            model(opc, a, b, er, ee);
            do_op(opc, a, b, addr, r, err, oopc, oaddr, lat, rdy);
            tests++;
            if (r !== er || err !== ee) begin
                fails++;
                $display("FAIL single_result opc=%0d a=%h b=%h got r=%h err=%b required r=%h err=%b",
                         opc, a, b, r, err, er, ee);
            end
            tests++;
            if (lat != 1) begin
                fails++;
                $display("FAIL single_latency opc=%0d got %0d required 1", opc, lat);
            end
            tests++;
            if (oopc !== opc || oaddr !== addr) begin
                fails++;
                $display("FAIL single_tag got opc=%0d addr=%0d required opc=%0d addr=%0d", oopc, oaddr, opc, addr);
            end
        end
    endtask

    task automatic test_div();
        logic [3:0]  to[8] = '{4'd6, 4'd7, 4'd6, 4'd7, 4'd6, 4'd7, 4'd6, 4'd7};
        logic [31:0] ta[8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000, 32'h5, 32'hFFFFFFF7, 32'd100, 32'd100};
        logic [31:0] tb[8] = '{32'h2, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [3:0] opc, oopc;
        logic [31:0] a, b;
        logic [4:0] addr, oaddr;
        logic [63:0] r, er;
        logic err, ee;
        int lat, rdy;
        for (int i = 0; i < 30; i++) begin
            if (i < 8) begin
                opc = to[i]; a = ta[i]; b = tb[i];
            end else begin
                opc = 4'($urandom_range(6, 7)); a = $urandom; b = rand_divisor();
            end
            addr = 5'($urandom);
            model(opc, a, b, er, ee);
            do_op(opc, a, b, addr, r, err, oopc, oaddr, lat, rdy);
            tests++;
            if (r !== er || err !== ee) begin
                fails++;
                $display("FAIL div_result opc=%0d a=%h b=%h got r=%h err=%b required r=%h err=%b",
                         opc, a, b, r, err, er, ee);
            end
            tests++;
            if (lat != exp_latency(opc, b)) begin
                fails++;
                $display("FAIL div_latency opc=%0d b=%h got %0d required %0d", opc, b, lat, exp_latency(opc, b));
            end
            tests++;
            if (rdy != 0) begin
                fails++;
                $display("FAIL div_in_ready_low got %0d cycles with in_ready high required 0", rdy);
            end
            tests++;
            if (oopc !== opc || oaddr !== addr) begin
                fails++;
                $display("FAIL div_tag got opc=%0d addr=%0d required opc=%0d addr=%0d", oopc, oaddr, opc, addr);
            end
        end
    endtask

    task automatic test_illegal();
        logic [3:0] opc, oopc;
        logic [31:0] a, b;
        logic [4:0] oaddr;
        logic [63:0] r;
        logic err;
        int lat, rdy;
        for (int i = 8; i < 16; i++) begin
            opc = 4'(i); a = $urandom; b = $urandom;
            do_op(opc, a, b, 5'(i), r, err, oopc, oaddr, lat, rdy);
            tests++;
            if (r !== 64'd0 || err !== 1'b1 || lat != 1) begin
                fails++;
                $display("FAIL illegal_opc opc=%0d got r=%h err=%b lat=%0d required r=0 err=1 lat=1",
                         opc, r, err, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, c, d;
        logic [63:0] em, ea;
        logic e1, e2;
        a = $urandom; b = $urandom; c = $urandom; d = $urandom;
        model(4'd5, a, b, em, e1);
        model(4'd3, c, d, ea, e2);
        @(negedge clk);
        in_opc = MULT; in_op_a = a; in_op_b = b; in_addr = 5'd9; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        in_opc = ADD; in_op_a = c; in_op_b = d; in_addr = 5'd21; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_op_r !== em || out_addr !== 5'd9 || out_opc !== MULT) begin
                fails++;
                $display("FAIL bp_hold cycle=%0d got valid=%b ready=%b r=%h addr=%0d required 1/0/%h/9",
                         k, out_valid, in_ready, out_op_r, out_addr, em);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release_ready got %b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_op_r !== ea || out_err !== e2 || out_addr !== 5'd21) begin
            fails++;
            $display("FAIL bp_next_add got valid=%b r=%h addr=%0d required 1/%h/21", out_valid, out_op_r, out_addr, ea);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_q[$];
        logic [63:0] er;
        logic ee;
        logic [3:0] opc;
        logic [31:0] a, b;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) begin
                tests++;
                if (out_valid !== 1'b1 || out_op_r !== exp_q[0]) begin
                    fails++;
                    $display("FAIL b2b_result idx=%0d got valid=%b r=%h required 1/%h", i - 1, out_valid, out_op_r, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            if (i < 12) begin
                opc = 4'($urandom_range(0, 5)); a = $urandom; b = $urandom;
                model(opc, a, b, er, ee);
                exp_q.push_back(er);
                in_opc = opcode_t'(opc); in_op_a = a; in_op_b = b; in_addr = 5'(i); in_valid = 1'b1;
                #1;
                tests++;
                if (in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_ready idx=%0d got %b required 1", i, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle got valid=%b busy=%b required 0/0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid_div();
        logic [3:0] oopc;
        logic [4:0] oaddr;
        logic [63:0] r, er;
        logic err, ee;
        int lat, rdy, spurious;
        logic [31:0] a, b;
        @(negedge clk);
        in_opc = DIV; in_op_a = 32'd1000; in_op_b = 32'd7; in_addr = 5'd17; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_err !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_flags got valid=%b busy=%b ready=%b err=%b required 0000",
                     out_valid, busy, in_ready, out_err);
        end
        tests++;
        if (out_op_r !== 64'd0 || out_addr !== 5'd0 || out_opc !== ZERO) begin
            fails++;
            $display("FAIL rst_mid_data got r=%h addr=%0d opc=%0d required 0/0/0", out_op_r, out_addr, out_opc);
        end
        @(negedge clk);
        reset_n = 1'b1;
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) spurious++;
        end
        tests++;
        if (spurious != 0) begin
            fails++;
            $display("FAIL rst_mid_spurious got %0d valid cycles required 0", spurious);
        end
        a = $urandom; b = rand_divisor();
        model(4'd7, a, b, er, ee);
        do_op(4'd7, a, b, 5'd3, r, err, oopc, oaddr, lat, rdy);
        tests++;
        if (r !== er || err !== ee || lat != exp_latency(4'd7, b)) begin
            fails++;
            $display("FAIL rst_mid_recover got r=%h err=%b lat=%0d required r=%h err=%b lat=%0d",
                     r, err, lat, er, ee, exp_latency(4'd7, b));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_div();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_exec_unit.md
# instr_exec_unit

Execute stage directly downstream of the instruction register: accepts one `instruction_t` operand pair plus opcode per handshake from the register's read port and produces the signed 64-bit result `op_r` with a tag. ZERO, PASSA, PASSB, ADD, SUB and MULT complete in one cycle. DIV and MOD run an iterative signed divider. One instruction is in flight at a time; the result is held until the consumer takes it.

## Interface
- `DIV_STEPS_PER_CYCLE`, default 1: quotient bits resolved per DIV_RUN cycle; legal values 1, 2, 4.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: instruction presented.
- `in_ready` out 1: unit can accept this cycle.
- `in_opc` in `opcode_t`: operation.
- `in_op_a`, `in_op_b` in `operand_t` (32, signed): operands.
- `in_addr` in `address_t` (5): source register slot; tag, passed through.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer takes result.
- `out_opc` out `opcode_t`: opcode of result.
- `out_addr` out `address_t`: tag of result.
- `out_op_r` out `operand_r` (64, signed): result.
- `out_err` out 1: divide by zero or illegal opcode.
- `busy` out 1: state is not IDLE.

## Operation
- FSM `exec_state_t` has three states: IDLE, DIV_RUN, DONE.
- Transfer on input: `in_valid && in_ready`. Transfer on output: `out_valid && out_ready`.
- `in_ready` = `reset_n && (IDLE || (DONE && out_ready))`. This allows back-to-back accepts while a result drains.
- On accept:
  - Non-divide opcode → DONE.
  - DIV/MOD with `op_b != 0` → DIV_RUN.
  - DIV/MOD with `op_b == 0` → DONE, `out_op_r=0`, `out_err=1`.
- DIV_RUN lasts exactly `32/DIV_STEPS_PER_CYCLE` cycles, then goes to DONE.
- DONE: `out_valid=1`. On output transfer with no accept → IDLE. With a simultaneous accept, follow the accept rules above.
- Arithmetic, all 64-bit sign-extended:
  - ZERO: 0.
  - PASSA / PASSB: `op_a` / `op_b`.
  - ADD / SUB: 33-bit exact result, sign-extended.
  - MULT: full 64-bit signed product.
  - DIV: quotient truncated toward zero.
  - MOD: remainder with the sign of the dividend.
- Divider works on unsigned magnitudes. `|−2^31| = 2^31` fits in 32 unsigned bits. Signs are fixed up on entry to DONE.
- `-2147483648 / -1` = `+2147483648` with no error. The matching MOD is 0.
- Opcode encodings 8–15: one-cycle path, `out_op_r=0`, `out_err=1`.
- `out_*` fields are stable while `out_valid && !out_ready`.

## Timing
- Reset values while `reset_n` is low, applied immediately (asynchronous):
  - State is IDLE.
  - `out_valid`, `in_ready`, `busy`, `out_err` are 0.
  - `out_op_r`, `out_addr` are 0; `out_opc` is ZERO.
  - Divider registers are 0.
- Reset mid-DIV_RUN or mid-DONE: the in-flight instruction is discarded and no result is emitted.
- Accept in cycle N, non-divide: `out_valid` high from N+1.
- Accept in cycle N, DIV/MOD: `out_valid` high from N+1+32/S, where S is `DIV_STEPS_PER_CYCLE`. With S=1 that is N+33.
- `in_ready` is low throughout DIV_RUN.
- `in_valid` held with `in_ready` low leaves the unit's state unchanged.
- Back-to-back single-cycle ops with `out_ready` held high: one result per cycle.

## Structure
- Add to `instr_register_pkg`:
  - `exec_state_t` enum.
  - `localparam DIV_WIDTH = 32`.
  - Function `is_div_op(opcode_t)`.
- Sub-module `instr_divider`: iterative unsigned restoring divider.
  - Parameters: `WIDTH`, `STEPS`.
  - Ports: `start`, operand magnitudes, `done`, quotient, remainder.
  - No sign logic inside it.
- Top level owns the FSM, sign handling, single-cycle datapath and output register.

## Test plan
- ADD `0x7FFFFFFF + 1` → `out_op_r = 0x0000_0000_8000_0000`, `out_err=0`, `out_valid` at N+1. SUB `0 - 1` → `0xFFFF_FFFF_FFFF_FFFF`.
- MULT `-3 * 7` → `-21`. MULT `0x80000000 * 0x80000000` → `0x4000_0000_0000_0000`.
- DIV `-7 / 2` → `-3`. MOD `-7 % 2` → `-1`. Both have `out_valid` exactly at N+33 with S=1, and `in_ready` low for the whole DIV_RUN.
- DIV `5 / 0` → `out_op_r=0`, `out_err=1` at N+1. Opcode 4'hF → `0`, `out_err=1`. DIV `-2^31 / -1` → `+2^31`, `out_err=0`.
- Backpressure: hold `out_ready=0` for 5 cycles in DONE. Outputs stay stable and `in_ready=0`. Then raise `out_ready` together with a new ADD: the result drains and the ADD is accepted in the same cycle.
- Assert `reset_n` low at DIV_RUN cycle 10. Outputs go to reset values at once, with no spurious `out_valid`. After release, the next instruction computes correctly.
